uart_rx_frame: RTL and testbench

Parametrised UART receiver that generalises the fixed 8N1 receiver to configurable data width, parity mode and stop-bit count. Filters its input with 3-sample majority voting and rejects false start bits. Reports parity and framing errors alongside each received word. Sits between the board RX pin and the command/packet parser in the monitor design.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_bit_sampler.sv | 55 +++++
 rtl/uart_rx_frame.sv | 124 ++++++++++++
 tb/tb_uart_rx_frame.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity codes and receiver state encoding
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_bit_sampler.sv
// rtl/uart_bit_sampler.sv - input synchronizer, falling-edge detect, bit timer and 3-sample majority vote
module uart_bit_sampler #(
    parameter int BAUD_DIV = 2604
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic run,
    output logic fall_edge,
    output logic bit_val,
    output logic bit_stb
);

    localparam logic [15:0] LAST    = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF    = 16'(BAUD_DIV / 2);
    localparam logic [15:0] HALF_M1 = HALF - 16'd1;
    localparam logic [15:0] HALF_P1 = HALF + 16'd1;

    logic        sync1;
    logic        sync2;
    logic        prev;
    logic [15:0] cnt;
    logic        samp_a;
    logic        samp_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            prev   <= 1'b1;
            cnt    <= '0;
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
            // Held at zero while idle so each frame starts from a clean count.
            if (!run || cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + 16'd1;
            if (run && cnt == HALF_M1)
                samp_a <= sync2;
            if (run && cnt == HALF)
                samp_b <= sync2;
        end
    end

    assign fall_edge = prev & ~sync2;
    assign bit_stb   = run && (cnt == HALF_P1);
    // Third vote is the live sample at the decision count.
    assign bit_val   = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - configurable UART receiver with parity and framing error reporting
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 2604,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [3:0] LAST_IDX  = 4'(DATA_W - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    rx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [3:0]        bit_idx;
    logic              par_acc;
    logic              par_err_l;
    logic              frm_err_l;
    logic              stop_cnt;
    logic              fall_edge;
    logic              bit_val;
    logic              bit_stb;

    uart_bit_sampler #(.BAUD_DIV(BAUD_DIV)) u_sampler (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .run       (state != ST_IDLE),
        .fall_edge (fall_edge),
        .bit_val   (bit_val),
        .bit_stb   (bit_stb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            par_acc    <= 1'b0;
            par_err_l  <= 1'b0;
            frm_err_l  <= 1'b0;
            stop_cnt   <= 1'b0;
            dout       <= '0;
            dout_vld   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dout_vld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fall_edge) begin
                        state     <= ST_START;
                        busy      <= 1'b1;
                        bit_idx   <= '0;
                        par_acc   <= 1'b0;
                        par_err_l <= 1'b0;
                        frm_err_l <= 1'b0;
                        stop_cnt  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_stb) begin
                        if (bit_val) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_stb) begin
                        shreg   <= {bit_val, shreg[DATA_W-1:1]};
                        par_acc <= par_acc ^ bit_val;
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == LAST_IDX)
                            state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (bit_stb) begin
                        // par_acc is the XOR of the data bits; odd mode wants the grand total odd.
                        if (PARITY == PAR_EVEN)
                            par_err_l <= par_acc ^ bit_val;
                        else
                            par_err_l <= ~(par_acc ^ bit_val);
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_stb) begin
                        if (stop_cnt == LAST_STOP) begin
                            dout       <= shreg;
                            dout_vld   <= 1'b1;
                            parity_err <= par_err_l;
                            frame_err  <= frm_err_l | ~bit_val;
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                        end else begin
                            stop_cnt  <= 1'b1;
                            frm_err_l <= frm_err_l | ~bit_val;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard bench for uart_rx_frame across three configurations
module tb_uart_rx_frame;

    localparam int BD = 16;
    localparam int HB = BD / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] din_v;

    logic [7:0] dout0, dout1;
    logic [4:0] dout2;
    logic       vld0, vld1, vld2;
    logic       perr0, perr1, perr2;
    logic       ferr0, ferr1, ferr2;
    logic       busy0, busy1, busy2;

    int n_vec = 0;
    int n_err = 0;

    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] q2[$];

    always #5 clk = ~clk;

    uart_rx_frame #(.BAUD_DIV(BD), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .din(din_v[0]), .dout(dout0), .dout_vld(vld0),
        .parity_err(perr0), .frame_err(ferr0), .busy(busy0));

    uart_rx_frame #(.BAUD_DIV(BD), .DATA_W(8), .PARITY(2), .STOP_BITS(2)) u_8e2 (
        .clk(clk), .rst(rst), .din(din_v[1]), .dout(dout1), .dout_vld(vld1),
        .parity_err(perr1), .frame_err(ferr1), .busy(busy1));

    uart_rx_frame #(.BAUD_DIV(BD), .DATA_W(5), .PARITY(1), .STOP_BITS(1)) u_5o1 (
        .clk(clk), .rst(rst), .din(din_v[2]), .dout(dout2), .dout_vld(vld2),
        .parity_err(perr2), .frame_err(ferr2), .busy(busy2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic score(input int which, input logic [8:0] data, input logic perr, input logic ferr);
        logic [10:0] e;
        int          sz;
        case (which)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            check($sformatf("unexpected_vld%0d", which), 32'(1), 32'(0));
        end else begin
            case (which)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("dout%0d", which), 32'(data), 32'(e[10:2]));
            check($sformatf("parity_err%0d", which), 32'(perr), 32'(e[1]));
            check($sformatf("frame_err%0d", which), 32'(ferr), 32'(e[0]));
        end
    endtask

    always @(negedge clk) begin
        if (vld0) score(0, {1'b0, dout0}, perr0, ferr0);
        if (vld1) score(1, {1'b0, dout1}, perr1, ferr1);
        if (vld2) score(2, {4'b0, dout2}, perr2, ferr2);
    end

    task automatic bit_out(input int which, input logic b, input bit glitch);
        for (int c = 0; c < BD; c++) begin
            din_v[which] = (glitch && c == HB + 1) ? ~b : b;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int which, input int n);
        din_v[which] = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // pmode: 0 none, 1 odd, 2 even. glitch_bit indexes frame bits with the start bit at 0.
    task automatic send_frame(input int which, input logic [8:0] data, input int dw, input int pmode,
                              input logic pbit, input int nstop, input logic stop0, input logic stop1,
                              input int glitch_bit);
        logic [8:0]  dexp;
        int          ones;
        logic        perr;
        logic        ferr;
        logic [10:0] e;
        int          pos;
        dexp = data & 9'((1 << dw) - 1);
        ones = $countones(dexp) + ((pmode != 0) ? int'(pbit) : 0);
        perr = (pmode == 1) ? (ones % 2 == 0) : (pmode == 2) ? (ones % 2 == 1) : 1'b0;
        ferr = !stop0 || (nstop == 2 && !stop1);
        e = {dexp, perr, ferr};
        case (which)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        bit_out(which, 1'b0, glitch_bit == 0);
        pos = 1;
        for (int i = 0; i < dw; i++) begin
            bit_out(which, dexp[i], glitch_bit == pos);
            pos++;
        end
        if (pmode != 0) bit_out(which, pbit, 1'b0);
        bit_out(which, stop0, 1'b0);
        if (nstop == 2) bit_out(which, stop1, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        din_v = 3'b111;
        repeat (3) @(negedge clk);
        check("rst_dout0", 32'(dout0), 32'(0));
        check("rst_vld_busy", 32'({vld0, vld1, vld2, busy0, busy1, busy2}), 32'(0));
        check("rst_errs", 32'({perr0, ferr0, perr1, ferr1, perr2, ferr2}), 32'(0));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 basic frame
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        check("busy0_after_a5", 32'(busy0), 32'(0));

        // even parity: correct then wrong parity bit
        send_frame(1, 9'h007, 8, 2, 1'b1, 2, 1'b1, 1'b1, -1);
        idle(1, BD);
        send_frame(1, 9'h007, 8, 2, 1'b0, 2, 1'b1, 1'b1, -1);
        idle(1, BD);

        // second stop bit low, then a clean frame
        send_frame(1, 9'h03C, 8, 2, 1'b0, 2, 1'b1, 1'b0, -1);
        idle(1, 2 * BD);
        send_frame(1, 9'h055, 8, 2, 1'b0, 2, 1'b1, 1'b1, -1);
        idle(1, BD);

        // false start glitch
        din_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("busy0_glitch_start", 32'(busy0), 32'(1));
        din_v[0] = 1'b1;
        repeat (BD - 3) @(negedge clk);
        check("busy0_false_start", 32'(busy0), 32'(0));
        idle(0, BD);

        // single-cycle inverted glitch at mid-bit
        send_frame(0, 9'h03B, 8, 0, 1'b0, 1, 1'b1, 1'b1, 3);
        idle(0, BD);
        send_frame(0, 9'h0C4, 8, 0, 1'b0, 1, 1'b1, 1'b1, 8);
        idle(0, BD);

        // back-to-back frames
        send_frame(0, 9'h012, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        send_frame(0, 9'h034, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        check("busy0_after_b2b", 32'(busy0), 32'(0));
        idle(0, BD);

        // reset in the middle of data bits
        bit_out(1, 1'b0, 1'b0);
        bit_out(1, 1'b1, 1'b0);
        bit_out(1, 1'b0, 1'b0);
        bit_out(1, 1'b1, 1'b0);
        check("busy1_mid_frame", 32'(busy1), 32'(1));
        rst      = 1'b1;
        din_v[1] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_dout1", 32'(dout1), 32'(0));
        check("rst_mid_flags1", 32'({vld1, perr1, ferr1, busy1}), 32'(0));
        idle(1, 2 * BD);
        send_frame(1, 9'h05A, 8, 2, 1'b0, 2, 1'b1, 1'b1, -1);
        idle(1, BD);

        // 5-bit odd parity
        send_frame(2, 9'h01F, 5, 1, 1'b0, 1, 1'b1, 1'b1, -1);
        idle(2, BD);
        send_frame(2, 9'h003, 5, 1, 1'b0, 1, 1'b1, 1'b1, -1);
        idle(2, 4 * BD);

        check("pending0", 32'(q0.size()), 32'(0));
        check("pending1", 32'(q1.size()), 32'(0));
        check("pending2", 32'(q2.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
